// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA decrypt block.
//   RSA_WIDTH   - default operand width for c, d, n and m
//   CYC_W       - width of the latency (cycles) output
//   rsa_state_e - top-level sequencer states
package rsa_pkg;
  localparam int RSA_WIDTH = 16;
  localparam int CYC_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    DONE
  } rsa_state_e;
endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: interleaved shift-add modular multiplier, p = a*b mod n.
// Processes one multiplier bit per cycle, MSB of b first, over WIDTH cycles.
//   clk, rst - clock, synchronous active-high reset
//   go       - held high for the whole multiplication; a, b, n must stay
//              stable while go is high. Back-to-back products are obtained
//              by keeping go high: a new product starts after each done.
//   a, b, n  - operands, a and b already reduced below n
//   p        - product, valid in the cycle done is high
//   done     - pulses on the WIDTH-th cycle of a multiplication
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = WIDTH + 2;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    idx;
  logic             last;

  // One iteration: acc = 2*acc mod n, then acc = acc + addend mod n.
  // Two guard bits keep 2*acc and acc+addend from overflowing before the
  // single conditional subtraction that brings each back below n.
  function automatic logic [WIDTH-1:0] mod_step(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] addend,
    input logic [WIDTH-1:0] modulus,
    input logic             add_en
  );
    logic [AW-1:0] t;
    logic [AW-1:0] m_ext;
    m_ext = {2'b00, modulus};
    t     = {1'b0, acc, 1'b0};
    if (t >= m_ext) t = t - m_ext;
    if (add_en) begin
      t = t + {2'b00, addend};
      if (t >= m_ext) t = t - m_ext;
    end
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    idx     = CW'(WIDTH - 1) - cnt_q;
    last    = (cnt_q == CW'(WIDTH - 1));
    acc_nxt = mod_step(acc_q, a, n, b[idx]);
    p       = acc_nxt;
    done    = go && last;

    cnt_d = '0;
    acc_d = '0;
    if (go && !last) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rsa_decrypt.sv
// rsa_decrypt: m = c^d mod n by left-to-right square-and-multiply.
// Every bit of d costs one WIDTH-cycle squaring, plus one WIDTH-cycle
// multiply when the bit is set, so latency deliberately depends on d.
//   clk, rst - clock, synchronous active-high reset
//   start    - one-cycle request, accepted only while busy is low;
//              c, d, n are sampled with it
//   c, d, n  - ciphertext, private exponent, modulus
//   m        - plaintext, updated on entry to DONE and then held
//   finish   - one-cycle pulse while m is valid
//   busy     - high from the accepted start through the finish cycle
//   err      - set with finish for n<2 or c>=n (m is then 0)
//   cycles   - latency of the last operation, start edge to finish end
module rsa_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] m,
  output logic             finish,
  output logic             busy,
  output logic             err,
  output logic [CYC_W-1:0] cycles
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_c_q, op_c_d;
  logic [WIDTH-1:0] op_d_q, op_d_d;
  logic [WIDTH-1:0] op_n_q, op_n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             err_q, err_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;

  logic             mm_go;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_p;
  logic             mm_done;

  rsa_modmul #(
    .WIDTH(WIDTH)
  ) u_modmul (
    .clk  (clk),
    .rst  (rst),
    .go   (mm_go),
    .a    (mm_a),
    .b    (r_q),
    .n    (op_n_q),
    .p    (mm_p),
    .done (mm_done)
  );

  always_comb begin
    state_d  = state_q;
    op_c_d   = op_c_q;
    op_d_d   = op_d_q;
    op_n_d   = op_n_q;
    r_d      = r_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    err_d    = err_q;
    cycles_d = cycles_q;
    mm_go    = 1'b0;
    mm_a     = r_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          op_c_d  = c;
          op_d_d  = d;
          op_n_d  = n;
          r_d     = WIDTH'(1);
          bit_d   = CW'(WIDTH - 1);
          cnt_d   = CYC_W'(1);
        end
      end

      LOAD: begin
        cnt_d = cnt_q + CYC_W'(1);
        if (op_n_q < WIDTH'(2) || op_c_q >= op_n_q) begin
          state_d  = DONE;
          m_d      = '0;
          err_d    = 1'b1;
          cycles_d = cnt_q + CYC_W'(1);
        end else begin
          state_d = SQR;
        end
      end

      SQR, MUL: begin
        cnt_d = cnt_q + CYC_W'(1);
        mm_go = 1'b1;
        if (state_q == MUL) mm_a = op_c_q;
        if (mm_done) begin
          r_d = mm_p;
          if (state_q == SQR && op_d_q[bit_q]) begin
            state_d = MUL;
          end else if (bit_q == '0) begin
            // Results are latched on entry to DONE so they are valid
            // throughout the finish cycle; cycles then equals the count
            // at the end of DONE.
            state_d  = DONE;
            m_d      = mm_p;
            err_d    = 1'b0;
            cycles_d = cnt_q + CYC_W'(1);
          end else begin
            state_d = SQR;
            bit_d   = bit_q - CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
    end
  end

  always_ff @(posedge clk) begin
    op_c_q <= op_c_d;
    op_d_q <= op_d_d;
    op_n_q <= op_n_d;
    r_q    <= r_d;
  end

  assign m      = m_q;
  assign err    = err_q;
  assign cycles = cycles_q;
  assign finish = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
- REQ-001 SHALL expose parameter WIDTH, default 16: operand width of c, d, n and m.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-004 SHALL have port start, input, 1: one-cycle request; c, d and n are sampled with it.
- REQ-005 SHALL have port c, input, WIDTH: ciphertext produced by the encrypt stage.
- REQ-006 SHALL have port d, input, WIDTH: private exponent.
- REQ-007 SHALL have port n, input, WIDTH: modulus.
- REQ-008 SHALL have port m, output, WIDTH: recovered plaintext, held until the next accepted start.
- REQ-009 SHALL have port finish, output, 1: one-cycle pulse when m is valid.
- REQ-010 SHALL have port busy, output, 1: high from the accepted start until finish, inclusive.
- REQ-011 SHALL have port err, output, 1: set with finish when inputs are illegal; held with m.
- REQ-012 SHALL have port cycles, output, 32: latency L of the last operation, latched at finish, used for timing-attack measurement.

Function
- REQ-013 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored with no effect.
- REQ-014 SHALL compute m = c^d mod n by left-to-right square-and-multiply over all WIDTH bits of d, MSB first, starting from r=1.
- REQ-015 SHALL, per bit i, do one modmul r=r*r mod n (SQR), then r=r*c mod n (MUL) only if d[i]=1; the data-dependent timing is intentional.
- REQ-016 SHALL implement each modmul as an interleaved shift-add multiplier: WIDTH iterations, one per cycle, MSB of multiplier first.
- REQ-017 Each modmul iteration SHALL compute acc=2*acc mod n, then acc=acc+a mod n if the multiplier bit is 1.
- REQ-018 Modmul internal width SHALL be WIDTH+2 bits so that no intermediate overflows.
- REQ-019 SHALL use FSM states IDLE, LOAD, SQR, MUL, DONE: IDLE->LOAD on accepted start; LOAD->SQR; SQR->MUL if d[i]=1; SQR->SQR(i-1) or DONE at i=0; MUL->SQR(i-1) or DONE at i=0; DONE->IDLE.
- REQ-020 Each SQR and MUL visit SHALL last exactly WIDTH cycles; LOAD and DONE SHALL last 1 cycle each.
- REQ-021 Latency L, from the start-sampling edge to the edge ending the finish cycle, SHALL be exactly 2 + WIDTH*(WIDTH+popcount(d)).
- REQ-022 If n<2 or c>=n at start, the block SHALL go LOAD->DONE, giving m=0, err=1 and L=2.
- REQ-023 With d=0 and legal inputs, the result SHALL be m=1.
- REQ-024 m, err and cycles SHALL update only in DONE; they SHALL be stable between operations.

Reset
- REQ-025 Asserting rst SHALL force, at the next clk edge: state=IDLE, m=0, finish=0, busy=0, err=0, cycles=0, internal counters=0.
- REQ-026 Reset mid-operation SHALL abort with no finish pulse; a start in the first cycle after rst deasserts SHALL be accepted.

Structure
- REQ-027 Package rsa_pkg SHALL hold the FSM state enum, the WIDTH default and the cycles width (32).
- REQ-028 The modular multiplier SHALL be one sub-module, rsa_modmul.
- REQ-029 rsa_modmul SHALL have ports clk, rst, go, a, b, n, p, done, with done pulsed on its WIDTH-th cycle.

Verification
- REQ-030 c=1394, d=2011, n=3127 -> m=89, err=0, finish at L=402, cycles=402.
- REQ-031 c=1394, d=0, n=3127 -> m=1, L=258; c=1394, d=1, n=3127 -> m=1394, L=274.
- REQ-032 c=3127, d=5, n=3127 -> m=0, err=1, L=2; n=1 -> same.
- REQ-033 Second start 10 cycles into a busy operation -> ignored; first result m=89 unchanged at L=402.
- REQ-034 rst at cycle 100 of an operation -> no finish, all outputs 0; a new start then gives the correct result.
- REQ-035 Back-to-back operations on d=2011 and d=0x0001 -> cycles differs by 16*(9-1)=128, confirming the timing leak.
